imm_extend_stage: RTL and testbench
===================================

Name: imm_extend_stage

Overview:
Parametrised, pipelined immediate generator for the next-generation core datapath.
- Takes the instruction immediate field (instr[31:7]) and a 3-bit format select.
- Produces an XLEN-wide sign- or zero-extended immediate for all RV32I formats (I, S, B, U, J) plus the CSR zimm format.
- Sits between decode and execute behind a valid/ready handshake, with a 2-entry output buffer so execute back-pressure never drops an immediate.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
ERR_CNT_W, 8, width of the saturating illegal-format counter.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high reset
inValid  input  1  upstream has a valid immediate request
inReady  output  1  block can accept a request this cycle
imm  input  25  instruction bits [31:7]; imm[k] = instr[k+7]
immSrc  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm), 110/111 illegal
unsignedExt  input  1  1 = zero-fill upper bits instead of sign-fill
outValid  output  1  buffer head holds a result
outReady  input  1  downstream accepts the head this cycle
extendedImm  output  XLEN  extended immediate at the buffer head
immError  output  1  head entry came from an illegal immSrc
errCount  output  ERR_CNT_W  saturating count of accepted illegal requests

Behaviour:
Format extraction (instr bit names; s = fill bit):
- I: {s.., instr[31:20]}.
- S: {s.., instr[31:25], instr[11:7]}.
- B: {s.., instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {s.., instr[31:12], 12'b0}; for XLEN=64, bits 63:32 use s.
- J: {s.., instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Z: {0.., instr[19:15]}; always zero-extended, unsignedExt ignored.
- Illegal (110/111): extendedImm = 0, immError = 1.

Fill and computation:
- s = instr[31] when unsignedExt = 0; s = 0 when unsignedExt = 1.
- Extension is computed combinationally and written into the buffer on accept; no X values are ever stored.

Handshake:
- Accept occurs on a rising edge with inValid & inReady.
- Pop occurs on a rising edge with outValid & outReady.
- inReady = ~reset & (occupancy != 2). It depends on registered state only; there is no combinational path from outReady.
- outValid = (occupancy != 0). extendedImm and immError always present the oldest entry.

Latency and ordering:
- 1 cycle: a request accepted at edge N is visible at the head after edge N when the buffer was empty.
- Order is strict FIFO.

Occupancy and edge cases:
- Occupancy 0..2, tracked by a 1-bit write pointer, 1-bit read pointer and a 2-bit count.
- Simultaneous accept and pop at occupancy 1: occupancy stays 1, head advances to the new entry on the next cycle.
- Simultaneous accept and pop at occupancy 0: not possible, since outValid = 0.
- At occupancy 2, inReady = 0; a pop frees one slot and inReady rises the following cycle.
- When empty, extendedImm holds its last value and immError holds 0.

errCount:
- Increments by 1 on each accepted illegal request.
- Saturates at 2^ERR_CNT_W - 1 with no wrap.
- Non-illegal requests leave it unchanged.

Reset (synchronous, dominates all other activity, including mid-transfer):
- Occupancy 0, pointers 0, outValid 0, inReady 0, extendedImm 0, immError 0, errCount 0.
- Buffered entries are discarded.
- inReady returns to 1 on the first cycle after reset deasserts.

Test Plan:
- I/sign and zero: instr 0xFFF00093, immSrc 000, unsignedExt 0 -> extendedImm 0xFFFFFFFF one cycle after accept. Same instr with unsignedExt 1 -> 0x00000FFF.
- B and J: instr 0xFE000EE3 (beq -4), immSrc 010 -> 0xFFFFFFFC. instr 0x0010006F (jal +2048), immSrc 100 -> 0x00000800.
- U and XLEN=64: instr 0x123450B7, immSrc 011 -> 0x12345000. Instr 0x800000B7 with XLEN=64 -> 0xFFFFFFFF80000000.
- Back-pressure: outReady held 0, push 3 back-to-back I requests (imm values 1, 2, 3) -> inReady drops after the 2nd accept and the 3rd waits. Release outReady -> 1, 2, 3 emerge in order with no loss or duplication.
- Illegal format: 300 accepted requests with immSrc 110 (ERR_CNT_W=8) -> every entry has immError=1 and extendedImm=0, errCount saturates at 255. A following legal request leaves errCount at 255 with immError=0.
- Mid-operation reset: buffer full, assert reset for 1 cycle -> next cycle outValid=0, errCount=0, extendedImm=0. inReady is 0 during reset and 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/imm_extend_stage.sv
// Immediate generator: extracts and extends I/S/B/U/J/Z immediates into a 2-entry output FIFO.
// Latency 1 cycle to head when empty; inReady depends only on registered occupancy, so outReady never reaches it.
module imm_extend_stage #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [24:0]          imm,
  input  logic [2:0]           immSrc,
  input  logic                 unsignedExt,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [XLEN-1:0]      extendedImm,
  output logic                 immError,
  output logic [ERR_CNT_W-1:0] errCount
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;
  localparam logic [2:0] SRC_Z = 3'b101;

  logic [31:7]          instr;
  logic                 s;
  logic                 hi_fill;
  logic                 illegal;
  logic [31:0]          res32;
  logic [XLEN-1:0]      new_imm;

  logic [XLEN-1:0]      mem_q [2];
  logic [XLEN-1:0]      mem_d [2];
  logic                 err_q [2];
  logic                 err_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [XLEN-1:0]      hold_q, hold_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 accept;
  logic                 pop;

  always_comb begin
    instr   = imm;
    s       = instr[31] & ~unsignedExt;
    hi_fill = s;
    illegal = 1'b0;
    res32   = '0;
    case (immSrc)
      SRC_I: res32 = {{20{s}}, instr[31:20]};
      SRC_S: res32 = {{20{s}}, instr[31:25], instr[11:7]};
      SRC_B: res32 = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SRC_U: res32 = {instr[31:12], 12'b0};
      SRC_J: res32 = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      SRC_Z: begin
        res32   = {27'b0, instr[19:15]};
        hi_fill = 1'b0;
      end
      default: begin
        illegal = 1'b1;
        hi_fill = 1'b0;
      end
    endcase
    // Upper half only exists for XLEN=64; every legal format except Z fills it with s.
    new_imm       = {XLEN{hi_fill}};
    new_imm[31:0] = res32;
  end

  assign inReady     = ~reset & (count_q != 2'd2);
  assign outValid    = (count_q != 2'd0);
  assign extendedImm = outValid ? mem_q[rd_ptr_q] : hold_q;
  assign immError    = outValid & err_q[rd_ptr_q];
  assign errCount    = err_cnt_q;

  assign accept = inValid & inReady;
  assign pop    = outValid & outReady;

  always_comb begin
    mem_d     = mem_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    hold_d    = hold_q;
    err_cnt_d = err_cnt_q;

    if (accept) begin
      mem_d[wr_ptr_q] = new_imm;
      err_d[wr_ptr_q] = illegal;
      wr_ptr_d        = ~wr_ptr_q;
      if (illegal && (err_cnt_q != {ERR_CNT_W{1'b1}}))
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    // The popped value is kept so the output stays stable once the buffer drains.
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      hold_d   = mem_q[rd_ptr_q];
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      err_q[0]  <= 1'b0;
      err_q[1]  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      hold_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: formats, XLEN=64 fill, back-pressure, illegal saturation, reset.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [24:0] imm;
  logic [2:0]  immSrc;
  logic        unsignedExt;
  logic        outValid;
  logic        outReady;
  logic [31:0] extendedImm;
  logic        immError;
  logic [7:0]  errCount;

  logic        inReady64;
  logic        outValid64;
  logic        outReady64;
  logic [63:0] extendedImm64;
  logic        immError64;
  logic [7:0]  errCount64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_extend_stage #(.XLEN(32), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .imm(imm), .immSrc(immSrc), .unsignedExt(unsignedExt),
    .outValid(outValid), .outReady(outReady), .extendedImm(extendedImm),
    .immError(immError), .errCount(errCount)
  );

  imm_extend_stage #(.XLEN(64), .ERR_CNT_W(8)) dut64 (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady64),
    .imm(imm), .immSrc(immSrc), .unsignedExt(unsignedExt),
    .outValid(outValid64), .outReady(outReady64), .extendedImm(extendedImm64),
    .immError(immError64), .errCount(errCount64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic uext);
    imm         = instr[31:7];
    immSrc      = src;
    unsignedExt = uext;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic push(input logic [31:0] instr, input logic [2:0] src, input logic uext);
    int n;
    drive(instr, src, uext);
    inValid = 1'b1;
    n = 0;
    while (!inReady && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("FAIL push_timeout inReady=%b required 1", inReady);
    end
    tick();
    inValid = 1'b0;
  endtask

  task automatic pop_one();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0;
    drive(32'h0, 3'b000, 1'b0);
    tick(); tick();
    checks++;
    if ({outValid, inReady, immError} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b required 000", {outValid, inReady, immError});
    end
    checks++;
    if ({extendedImm, errCount} !== 40'h0) begin
      failures++;
      $display("FAIL reset_values imm=%h err=%0d required 0/0", extendedImm, errCount);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_release inReady=%b required 1", inReady);
    end
  endtask

  task automatic test_i_s_z();
    push(32'hFFF00093, 3'b000, 1'b0);
    checks++;
    if ({outValid, immError, extendedImm} !== {2'b10, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL i_sign v=%b e=%b imm=%h required 1/0/ffffffff", outValid, immError, extendedImm);
    end
    pop_one();
    push(32'hFFF00093, 3'b000, 1'b1);
    checks++;
    if (extendedImm !== 32'h00000FFF) begin
      failures++;
      $display("FAIL i_zero imm=%h required 00000fff", extendedImm);
    end
    pop_one();
    push(32'hFE112C23, 3'b001, 1'b0);
    checks++;
    if (extendedImm !== 32'hFFFFFFF8) begin
      failures++;
      $display("FAIL s_fmt imm=%h required fffffff8", extendedImm);
    end
    pop_one();
    push(32'h800FD073, 3'b101, 1'b0);
    checks++;
    if (extendedImm !== 32'h0000001F) begin
      failures++;
      $display("FAIL z_fmt imm=%h required 0000001f", extendedImm);
    end
    pop_one();
  endtask

  task automatic test_b_j();
    push(32'hFE000EE3, 3'b010, 1'b0);
    checks++;
    if (extendedImm !== 32'hFFFFFFFC) begin
      failures++;
      $display("FAIL b_fmt imm=%h required fffffffc", extendedImm);
    end
    pop_one();
    push(32'h0010006F, 3'b100, 1'b0);
    checks++;
    if (extendedImm !== 32'h00000800) begin
      failures++;
      $display("FAIL j_fmt imm=%h required 00000800", extendedImm);
    end
    pop_one();
  endtask

  task automatic test_u_xlen64();
    push(32'h123450B7, 3'b011, 1'b0);
    checks++;
    if (extendedImm !== 32'h12345000) begin
      failures++;
      $display("FAIL u_fmt imm=%h required 12345000", extendedImm);
    end
    checks++;
    if ({outValid64, extendedImm64} !== {1'b1, 64'h0000000012345000}) begin
      failures++;
      $display("FAIL u_x64_pos v=%b imm=%h required 1/0000000012345000", outValid64, extendedImm64);
    end
    pop_one();
    push(32'h800000B7, 3'b011, 1'b0);
    checks++;
    if (extendedImm64 !== 64'hFFFFFFFF80000000) begin
      failures++;
      $display("FAIL u_x64_neg imm=%h required ffffffff80000000", extendedImm64);
    end
    checks++;
    if (extendedImm !== 32'h80000000) begin
      failures++;
      $display("FAIL u_x32_neg imm=%h required 80000000", extendedImm);
    end
    pop_one();
    push(32'h800000B7, 3'b011, 1'b1);
    checks++;
    if (extendedImm64 !== 64'h0000000080000000) begin
      failures++;
      $display("FAIL u_x64_zero imm=%h required 0000000080000000", extendedImm64);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    outReady = 1'b0;
    drive(32'h00100093, 3'b000, 1'b0);
    inValid = 1'b1;
    tick();
    drive(32'h00200093, 3'b000, 1'b0);
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_after_1 inReady=%b required 1", inReady);
    end
    tick();
    drive(32'h00300093, 3'b000, 1'b0);
    tick(); tick();
    checks++;
    if ({inReady, outValid, extendedImm} !== {2'b01, 32'd1}) begin
      failures++;
      $display("FAIL bp_full rdy=%b v=%b imm=%h required 0/1/1", inReady, outValid, extendedImm);
    end
    outReady = 1'b1;
    tick();
    checks++;
    if ({inReady, extendedImm} !== {1'b1, 32'd2}) begin
      failures++;
      $display("FAIL bp_after_pop1 rdy=%b imm=%h required 1/2", inReady, extendedImm);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if ({outValid, extendedImm} !== {1'b1, 32'd3}) begin
      failures++;
      $display("FAIL bp_after_pop2 v=%b imm=%h required 1/3", outValid, extendedImm);
    end
    tick();
    outReady = 1'b0;
    checks++;
    if ({outValid, immError, extendedImm} !== {2'b00, 32'd3}) begin
      failures++;
      $display("FAIL bp_drained v=%b e=%b imm=%h required 0/0/3", outValid, immError, extendedImm);
    end
  endtask

  task automatic test_illegal();
    outReady = 1'b1;
    inValid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      imm    = 25'($urandom);
      immSrc = (i % 2 == 1) ? 3'b111 : 3'b110;
      unsignedExt = 1'b0;
      tick();
      checks++;
      if ({outValid, immError, extendedImm} !== {2'b11, 32'd0}) begin
        failures++;
        $display("FAIL illegal_entry i=%0d v=%b e=%b imm=%h required 1/1/0", i, outValid, immError, extendedImm);
      end
      if (i == 99) begin
        checks++;
        if (errCount !== 8'd100) begin
          failures++;
          $display("FAIL err_count_100 got=%0d required 100", errCount);
        end
      end
    end
    inValid = 1'b0;
    tick();
    outReady = 1'b0;
    checks++;
    if (errCount !== 8'd255) begin
      failures++;
      $display("FAIL err_count_sat got=%0d required 255", errCount);
    end
    push(32'h00500093, 3'b000, 1'b0);
    checks++;
    if ({errCount, immError, extendedImm} !== {8'd255, 1'b0, 32'd5}) begin
      failures++;
      $display("FAIL legal_after_illegal cnt=%0d e=%b imm=%h required 255/0/5", errCount, immError, extendedImm);
    end
    pop_one();
  endtask

  task automatic test_mid_reset();
    outReady = 1'b0;
    push(32'h00A00093, 3'b000, 1'b0);
    push(32'h00B00093, 3'b110, 1'b0);
    checks++;
    if ({inReady, outValid} !== 2'b01) begin
      failures++;
      $display("FAIL mr_full rdy=%b v=%b required 0/1", inReady, outValid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({outValid, inReady, immError, errCount, extendedImm} !== 43'h0) begin
      failures++;
      $display("FAIL mr_during v=%b rdy=%b e=%b cnt=%0d imm=%h required all 0", outValid, inReady, immError, errCount, extendedImm);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("FAIL mr_release inReady=%b required 1", inReady);
    end
    push(32'h00700093, 3'b000, 1'b0);
    checks++;
    if ({outValid, extendedImm} !== {1'b1, 32'd7}) begin
      failures++;
      $display("FAIL mr_fresh v=%b imm=%h required 1/7", outValid, extendedImm);
    end
    tick();
    checks++;
    if (outValid !== 1'b1) begin
      failures++;
      $display("FAIL mr_single_entry v=%b required 1", outValid);
    end
    pop_one();
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("FAIL mr_discarded v=%b required 0", outValid);
    end
  endtask

  initial begin
    outReady64 = 1'b1;
    test_reset();
    test_i_s_z();
    test_b_j();
    test_u_xlen64();
    test_back_to_back();
    test_illegal();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
